// File: rtl/seq_alu_exec_pkg.sv
// ============================================================================
// Module  : seq_alu_exec_pkg
// Brief   : Shared ALU operation codes, FSM state encoding and op-class helpers
//           for the sequential execution ALU.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_alu_exec_pkg;

  // 4-bit operation codes emitted by the ALU control decoder
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1010;
  localparam logic [3:0] ALU_SRL = 4'b1011;

  // Execution FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_t;

  // True for the two shift operations
  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL);
  endfunction

  // True for any code in the supported encoding list
  function automatic logic is_known_op(input logic [3:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_AND) ||
           (op == ALU_OR)  || (op == ALU_XOR) || is_shift_op(op);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_alu_shifter.sv
// ============================================================================
// Module  : seq_alu_shifter
// Brief   : Shift engine for seq_alu_exec. Default build: iterative shifter
//           holding an accumulator and a remaining-count, one bit per step.
//           With SEQ_ALU_BARREL_EN defined: purely combinational barrel shift.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_alu_shifter #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
`ifndef SEQ_ALU_BARREL_EN
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_load,
  input  logic               i_step,
`endif
  input  logic               i_left,
  input  logic [XLEN-1:0]    i_a,
  input  logic [SHAMT_W-1:0] i_shamt,
  output logic [XLEN-1:0]    o_result,
  output logic               o_last
);

`ifdef SEQ_ALU_BARREL_EN

  // Whole shift in one combinational pass; there is never a final step
  always_comb begin
    o_result = i_left ? (i_a << i_shamt) : (i_a >> i_shamt);
    o_last   = 1'b0;
  end

`else

  logic [XLEN-1:0]    r_acc;
  logic [SHAMT_W-1:0] r_cnt;
  logic               r_left;

  // Accumulator, remaining count and direction, captured on load and
  // advanced one bit per step
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_left <= 1'b0;
    end else if (i_load) begin
      r_acc  <= i_a;
      r_cnt  <= i_shamt;
      r_left <= i_left;
    end else if (i_step) begin
      r_acc  <= o_result;
      r_cnt  <= r_cnt - 1'b1;
    end
  end

  // One-bit shifted accumulator; this is the value written back on the
  // step where the count reaches 1, so it doubles as the final result
  always_comb begin
    o_result = r_left ? {r_acc[XLEN-2:0], 1'b0} : {1'b0, r_acc[XLEN-1:1]};
    o_last   = (r_cnt == {{(SHAMT_W-1){1'b0}}, 1'b1});
  end

`endif

endmodule

`default_nettype wire

// File: rtl/seq_alu_exec.sv
// ============================================================================
// Module  : seq_alu_exec
// Brief   : Multi-cycle ALU with valid/ready handshakes on input and output.
//           ADD/SUB/AND/OR/XOR finish in one cycle; SLL/SRL iterate one bit
//           per cycle unless macro SEQ_ALU_BARREL_EN selects a barrel shifter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_alu_exec
  import seq_alu_exec_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic            alu_zero,
  output logic            alu_err
);

  alu_state_t          r_state;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [XLEN-1:0]     r_result;
  logic                r_zero;
  logic                r_err;

  logic                w_accept;
  logic [SHAMT_W-1:0]  w_shamt;
  logic                w_left;
  logic                w_go_shift;
  logic [XLEN-1:0]     w_shift_res;
  logic                w_shift_last;
  logic [XLEN-1:0]     w_single_res;
  logic                w_unknown;

  assign w_accept = in_valid && r_in_ready;
  assign w_shamt  = operand_b[SHAMT_W-1:0];
  assign w_left   = (alu_op == ALU_SLL);

`ifdef SEQ_ALU_BARREL_EN
  assign w_go_shift = 1'b0;
`else
  assign w_go_shift = is_shift_op(alu_op) && (w_shamt != '0);
`endif

  seq_alu_shifter #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
`ifndef SEQ_ALU_BARREL_EN
    .clk      (clk),
    .reset_n  (reset_n),
    .i_load   (w_accept && w_go_shift),
    .i_step   (r_state == ST_SHIFT),
`endif
    .i_left   (w_left),
    .i_a      (operand_a),
    .i_shamt  (w_shamt),
    .o_result (w_shift_res),
    .o_last   (w_shift_last)
  );

  // Result of any op that completes on the accept edge; a zero-distance
  // iterative shift simply passes operand_a through
  always_comb begin
    w_single_res = '0;
    w_unknown    = !is_known_op(alu_op);
    case (alu_op)
      ALU_ADD: w_single_res = operand_a + operand_b;
      ALU_SUB: w_single_res = operand_a - operand_b;
      ALU_AND: w_single_res = operand_a & operand_b;
      ALU_OR:  w_single_res = operand_a | operand_b;
      ALU_XOR: w_single_res = operand_a ^ operand_b;
`ifdef SEQ_ALU_BARREL_EN
      ALU_SLL, ALU_SRL: w_single_res = w_shift_res;
`else
      ALU_SLL, ALU_SRL: w_single_res = operand_a;
`endif
      default: w_single_res = '0;
    endcase
  end

  // Control FSM with registered handshake and result outputs; in_ready is
  // registered so it stays low throughout reset and rises one edge after
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_in_ready <= 1'b0;
            if (w_go_shift) begin
              r_state <= ST_SHIFT;
            end else begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
              r_result    <= w_single_res;
              r_zero      <= (w_single_res == '0);
              r_err       <= w_unknown;
            end
          end else begin
            r_in_ready <= 1'b1;
          end
        end
`ifndef SEQ_ALU_BARREL_EN
        ST_SHIFT: begin
          if (w_shift_last) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_shift_res;
            r_zero      <= (w_shift_res == '0);
            r_err       <= 1'b0;
          end
        end
`endif
        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign alu_result = r_result;
  assign alu_zero   = r_zero;
  assign alu_err    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_seq_alu_exec.sv
// ============================================================================
// Module  : tb_seq_alu_exec
// Brief   : Self-checking scoreboard bench for seq_alu_exec. Builds with or
//           without SEQ_ALU_BARREL_EN; expected latencies follow the macro.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_alu_exec;

  localparam int XLEN = 32;

  logic            clk;
  logic            reset_n;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;
  logic            alu_err;

  typedef struct {
    logic [XLEN-1:0] res;
    logic            zero;
    logic            err;
    int              lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  seq_alu_exec #(.XLEN(XLEN), .SHAMT_W(5)) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_op     (alu_op),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .alu_err    (alu_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model; latency = edges after the accept edge before out_valid
  // is seen (0 = registered on the accept edge itself)
  function automatic exp_t model(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    exp_t e;
    int   sh;
    sh    = int'(b[4:0]);
    e.err = 1'b0;
    e.lat = 0;
    case (op)
      4'b0000: e.res = a + b;
      4'b0001: e.res = a - b;
      4'b0100: e.res = a & b;
      4'b0101: e.res = a | b;
      4'b1000: e.res = a ^ b;
      4'b1010: e.res = a << sh;
      4'b1011: e.res = a >> sh;
      default: begin e.res = '0; e.err = 1'b1; end
    endcase
`ifndef SEQ_ALU_BARREL_EN
    if ((op == 4'b1010 || op == 4'b1011) && sh != 0) e.lat = sh;
`endif
    e.zero = (e.res == '0);
    return e;
  endfunction

  // Issue one op, wait for its result, hold it for 'hold' cycles of
  // backpressure, then take it and confirm the block is ready again
  task automatic run_op(input string tag, input logic [3:0] op, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input int hold);
    exp_t e;
    int   lat;
    bit   rdy;
    rdy = 1'b0;
    for (int i = 0; i < 50 && !rdy; i++) begin
      @(negedge clk);
      if (in_ready) rdy = 1'b1;
    end
    if (!rdy) begin
      check({tag, "_in_ready_timeout"}, 0, 1);
      return;
    end
    in_valid  = 1'b1;
    alu_op    = op;
    operand_a = a;
    operand_b = b;
    sb.push_back(model(op, a, b));
    @(posedge clk);
    @(negedge clk);
    // Inputs after accept must be ignored
    in_valid  = 1'b0;
    alu_op    = 4'($urandom);
    operand_a = $urandom;
    operand_b = $urandom;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    if (!out_valid) begin
      check({tag, "_out_valid_timeout"}, 0, 1);
      return;
    end
    check({tag, "_lat"}, lat, e.lat);
    check({tag, "_res"}, alu_result, e.res);
    check({tag, "_zero"}, alu_zero, e.zero);
    check({tag, "_err"}, alu_err, e.err);
    check({tag, "_busy"}, in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_res"}, alu_result, e.res);
      check({tag, "_hold_busy"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_taken"}, out_valid, 0);
    check({tag, "_ready_again"}, in_ready, 1);
  endtask

  initial begin
    bit saw_valid;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    alu_op    = '0;
    operand_a = '0;
    operand_b = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_result", alu_result, 0);
    check("rst_err", alu_err, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_in_ready", in_ready, 1);

    // Single-cycle arithmetic and logic
    run_op("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'h1, 0);
    run_op("sub_neg", 4'b0001, 32'd5, 32'd7, 0);
    run_op("and", 4'b0100, 32'hF0F0_1234, 32'h0FF0_FF00, 0);
    run_op("or", 4'b0101, 32'hA000_0001, 32'h0500_0010, 0);

    // Shifts
    run_op("sll31", 4'b1010, 32'h1, 32'd31, 0);
    run_op("srl4", 4'b1011, 32'h8000_0000, 32'd4, 0);
    run_op("sll0", 4'b1010, 32'hDEAD_BEEF, 32'h20, 0);
    run_op("srl1", 4'b1011, 32'h0000_0003, 32'd1, 0);

    // Backpressure
    run_op("xor_bp", 4'b1000, 32'hF0, 32'hFF, 5);

    // Unknown op
    run_op("unk", 4'b0111, 32'h1234_5678, 32'h1, 0);

    // Reset in the middle of a long shift
    @(negedge clk);
    in_valid  = 1'b1;
    alu_op    = 4'b1010;
    operand_a = 32'h1;
    operand_b = 32'd20;
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    @(negedge clk);
    reset_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check("midrst_no_output", saw_valid, 0);
    run_op("post_rst_add", 4'b0000, 32'd100, 32'd23, 0);
    run_op("post_rst_sll", 4'b1010, 32'h3, 32'd3, 0);

    // A few random valid ops with short shift distances
    for (int i = 0; i < 6; i++) begin
      logic [3:0] op;
      logic [XLEN-1:0] b;
      case ($urandom_range(0, 6))
        0: op = 4'b0000;
        1: op = 4'b0001;
        2: op = 4'b0100;
        3: op = 4'b0101;
        4: op = 4'b1000;
        5: op = 4'b1010;
        default: op = 4'b1011;
      endcase
      b = $urandom;
      if (op[3:1] == 3'b101) b[4:0] = 5'($urandom_range(0, 9));
      run_op("rand", op, $urandom, b, int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard stop in case anything above stalls
  initial begin
    #200000;
    $display("FAIL global_timeout: got stall expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
